multiplication_n_digit: RTL
===========================

// Module: multiplication_n_digit
// PURPOSE
//  Sequential radix-2 shift-add multiplier for unsigned fixed-point operands with DIGIT fraction bits.
//  It is the inverse of the restoring divider: it rebuilds dividend-scale values from a quotient and a divisor.
//  It sits beside the divider in the arithmetic library and is driven by the same start/done control FSMs.
//  The full-precision product has 2*N integer bits and 2*DIGIT fraction bits, so it never overflows.
// PARAMETERS
//  N      32  integer bits per operand
//  DIGIT  16  fraction bits per operand; W = N+DIGIT is the operand width and the iteration count
// PORTS
//  clk_i     in   1          single clock, rising edge
//  rst_i     in   1          asynchronous, active-high reset
//  start_i   in   1          request; sampled only in IDLE or DONE
//  a_int_i   in   N          multiplicand integer part
//  a_frac_i  in   DIGIT      multiplicand fraction part
//  b_int_i   in   N          multiplier integer part
//  b_frac_i  in   DIGIT      multiplier fraction part
//  busy_o    out  1          high while iterating
//  done_o    out  1          one-cycle pulse: product valid
//  p_int_o   out  2N         product integer part
//  p_frac_o  out  2*DIGIT    product fraction part
//  iter_o    out  clog2(W)   remaining-iteration counter (debug)
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; busy_o=0, done_o=0, p_int_o=0, p_frac_o=0, iter_o=0; accumulator cleared.
//  - Operand view: A={a_int_i,a_frac_i} and B={b_int_i,b_frac_i}, W bits each.
//    Product P=A*B is 2W bits, with p_int_o=P[2W-1:2*DIGIT] and p_frac_o=P[2*DIGIT-1:0].
//  - FSM states: IDLE, BUSY, DONE.
//    - IDLE --start_i--> BUSY. At that edge: mcand<=A zero-extended to 2W; mplier<=B; acc<=0; iter<=W-1.
//    - BUSY, each edge:
//        - if mplier[0], acc<=acc+mcand;
//        - mcand<<=1; mplier>>=1; iter<=iter-1.
//      At the edge where iter==0 it performs the final step, loads the p_* registers with the final sum, and moves to DONE.
//    - DONE: done_o=1 for exactly this cycle.
//      - start_i=1: accept a new operation exactly as from IDLE (back-to-back, no bubble).
//      - otherwise: go to IDLE.
//  - busy_o = (state==BUSY). done_o = (state==DONE). Both are registered-state decodes and glitch-free.
//  - Latency: start sampled at edge E0 -> done_o high in the cycle after edge E0+W, i.e. W+1 edges from request to result.
//  - p_int_o/p_frac_o are updated only on the BUSY->DONE edge.
//    They hold their value through IDLE and through the next operation, until its own BUSY->DONE edge.
//  - start_i while BUSY: ignored, with no effect on the operation in flight.
//  - Operands are captured only at the accept edge. Input changes during BUSY are ignored.
//  - The adder is 2W bits wide. The accumulator cannot carry out, because the max product is (2^W-1)^2 < 2^(2W).
//  - Reset asserted mid-operation: abort immediately, with all outputs per the reset row above.
//    No done_o is issued for the aborted operation.
//  - Zero operands follow the same fixed W-cycle timing. There is no early termination.
// STRUCTURE
//  - Package mult_pkg:
//      - typedef enum logic [1:0] {IDLE,BUSY,DONE} mult_state_e;
//      - localparam function mult_w(N,DIGIT)=N+DIGIT.
//  - Sub-module mult_datapath_n #(W), one instance. Contents:
//      - mcand/mplier/acc registers and the conditional 2W-bit add;
//      - load and step enables driven by the FSM.
//    The top holds the FSM, iteration counter and output registers.
//  - Reuse the existing library mux2to1_n for the add/no-add select.
// TESTING (defaults N=32, DIGIT=16, W=48)
//  - 3.5*2.25: a=3/0x8000, b=2/0x4000 -> p_int_o=7, p_frac_o=0xE000_0000.
//    done_o appears exactly 49 edges after the start edge; busy_o is high for 48 cycles.
//  - Zero: a=0/0, b=0xFFFF_FFFF/0xFFFF -> p=0, with the same 49-edge latency.
//  - Max*max: a=b=all ones -> {p_int_o,p_frac_o} = 2^96-2^49+1, with no wrap.
//  - Back-to-back: start_i held high with a second operand pair, 1.0*1.0 -> p_int_o=1, p_frac_o=0.
//    Its done_o comes 49 edges after the first done cycle, with no IDLE cycle in between.
//  - Ignore while busy: pulse start_i with new operands at BUSY cycle 10 -> the first result is unchanged and only one done_o fires.
//  - Reset mid-op: assert rst_i at BUSY cycle 20 for 1 cycle -> all outputs 0 asynchronously and no done_o.
//    A following 2.0*3.0 then yields p_int_o=6.

Source files
------------

// File: rtl/mult_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mult_pkg : shared types and sizing helper for the shift-add multiplier
// Rev 1.0
// ---------------------------------------------------------------------------
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mult_state_e;

  function automatic int mult_w(input int n, input int digit);
    return n + digit;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult_datapath_n.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mult_datapath_n : multiplicand/multiplier/accumulator registers and 2W adder
// Rev 1.0
// ---------------------------------------------------------------------------
module mult_datapath_n #(
  parameter int W = 48
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           load_i,
  input  logic           step_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] next_acc_o
);

  logic [2*W-1:0] mcand_q;
  logic [W-1:0]   mplier_q;
  logic [2*W-1:0] acc_q;
  logic [2*W-1:0] addend;
  logic [2*W-1:0] sum;

  mux2to1_n #(
    .N (2*W)
  ) u_add_sel (
    .sel_i (mplier_q[0]),
    .d0_i  ({(2*W){1'b0}}),
    .d1_i  (mcand_q),
    .y_o   (addend)
  );

  // Cannot carry out: the largest product (2^W-1)^2 fits in 2W bits.
  assign sum        = acc_q + addend;
  assign next_acc_o = sum;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (load_i) begin
      mcand_q  <= {{W{1'b0}}, a_i};
      mplier_q <= b_i;
      acc_q    <= '0;
    end else if (step_i) begin
      acc_q    <= sum;
      mcand_q  <= {mcand_q[2*W-2:0], 1'b0};
      mplier_q <= {1'b0, mplier_q[W-1:1]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/mux2to1_n.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mux2to1_n : N-bit two-input multiplexer (library cell)
// Rev 1.0
// ---------------------------------------------------------------------------
module mux2to1_n #(
  parameter int N = 8
) (
  input  logic         sel_i,
  input  logic [N-1:0] d0_i,
  input  logic [N-1:0] d1_i,
  output logic [N-1:0] y_o
);

  assign y_o = sel_i ? d1_i : d0_i;

endmodule
`default_nettype wire

// File: rtl/multiplication_n_digit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multiplication_n_digit : sequential radix-2 fixed-point multiplier, W-cycle
// Rev 1.0
// ---------------------------------------------------------------------------
module multiplication_n_digit #(
  parameter int N     = 32,
  parameter int DIGIT = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic [N-1:0]                a_int_i,
  input  logic [DIGIT-1:0]            a_frac_i,
  input  logic [N-1:0]                b_int_i,
  input  logic [DIGIT-1:0]            b_frac_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [2*N-1:0]              p_int_o,
  output logic [2*DIGIT-1:0]          p_frac_o,
  output logic [$clog2(N+DIGIT)-1:0]  iter_o
);

  import mult_pkg::*;

  localparam int W  = mult_w(N, DIGIT);
  localparam int IW = $clog2(N + DIGIT);

  mult_state_e      state_q;
  logic [IW-1:0]    iter_q;
  logic [2*W-1:0]   p_q;
  logic [2*W-1:0]   next_acc;
  logic             load;
  logic             step;

  // DONE accepts a new request exactly like IDLE, giving back-to-back issue.
  assign load = start_i && ((state_q == IDLE) || (state_q == DONE));
  assign step = (state_q == BUSY);

  mult_datapath_n #(
    .W (W)
  ) u_datapath (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (load),
    .step_i     (step),
    .a_i        ({a_int_i, a_frac_i}),
    .b_i        ({b_int_i, b_frac_i}),
    .next_acc_o (next_acc)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      iter_q  <= '0;
      p_q     <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            state_q <= BUSY;
            iter_q  <= IW'(W - 1);
          end else begin
            state_q <= IDLE;
          end
        end
        BUSY: begin
          iter_q <= iter_q - IW'(1);
          if (iter_q == '0) begin
            p_q     <= next_acc;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o   = (state_q == BUSY);
  assign done_o   = (state_q == DONE);
  assign p_int_o  = p_q[2*W-1:2*DIGIT];
  assign p_frac_o = p_q[2*DIGIT-1:0];
  assign iter_o   = iter_q;

endmodule
`default_nettype wire
